aq_expand: RTL and testbench

- Streaming image enlarger, the upscaling counterpart of the area-averaging reducer. Uses the same DIN/DOUT pixel-stream conventions.
- Takes an ORG_X x ORG_Y frame of 32-bit ARGB pixels and emits a CNV_X x CNV_Y frame (CNV >= ORG) using nearest-neighbour replication.
- One input line is held in a line buffer and replayed for every output row that maps to it. Input is throttled by DIN_READY because the output rate exceeds the input rate.

---
 rtl/aq_expand.sv | 223 ++++++++++++++++++++++
 tb/tb_aq_expand.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_expand.sv
// Streaming nearest-neighbour image enlarger. One source line is held in a line
// buffer and replayed for every output row that maps onto it.
module aq_expand #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [15:0]       ORG_X,
   input  logic [15:0]       ORG_Y,
   input  logic [15:0]       CNV_X,
   input  logic [15:0]       CNV_Y,
   input  logic              DIN_FSYNC,
   input  logic              DIN_WE,
   input  logic [DATA_W-1:0] DIN,
   output logic              DIN_READY,
   output logic              DOUT_OE,
   output logic              DOUT_FSYNC,
   output logic              DOUT_LAST,
   output logic [DATA_W-1:0] DOUT,
   output logic              CFG_ERR
);

   localparam int unsigned BUF_DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned ACC_W     = 17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EMIT,
      ST_ROWEND,
      ST_DISCARD
   } state_t;

   state_t             r_state, w_state_nx;
   logic [CNT_W-1:0]   r_org_x, r_org_y, r_cnv_x, r_cnv_y;
   logic [CNT_W-1:0]   w_org_x_nx, w_org_y_nx, w_cnv_x_nx, w_cnv_y_nx;
   logic [CNT_W-1:0]   r_cnt_x, w_cnt_x_nx, r_src_x, w_src_x_nx;
   logic [CNT_W-1:0]   r_out_row, w_out_row_nx, r_in_row, w_in_row_nx;
   logic [ACC_W-1:0]   r_acc_x, w_acc_x_nx, r_acc_y, w_acc_y_nx;
   logic               r_cfg_err, w_cfg_err_nx;

   logic               w_cfg_bad, w_xfer, w_buf_we, w_rd_issue, w_rd_last;
   logic [ACC_W-1:0]   w_acc_x_sum, w_acc_y_sum;
   logic [CNT_W-1:0]   w_cnt_x_inc, w_out_row_inc;

   logic [DATA_W-1:0]  r_buf [BUF_DEPTH];
   logic [DATA_W-1:0]  r_rd_data;
   logic               r_rd_v, r_rd_last;
   logic               r_dout_oe, r_dout_fsync, r_dout_last;
   logic [DATA_W-1:0]  r_dout;

   assign w_cfg_bad = (ORG_X == '0) || (ORG_Y == '0) || (ORG_X > CNV_X) || (ORG_Y > CNV_Y)
                    || (32'(ORG_X) > BUF_DEPTH);

   // A frame-start pulse always wins over a pixel offered in the same cycle.
   assign DIN_READY = ~DIN_FSYNC & ((r_state == ST_DISCARD) ||
                                    ((r_state == ST_LOAD) && (r_cnt_x < r_org_x)));
   assign w_xfer    = DIN_WE & DIN_READY;
   assign w_buf_we  = w_xfer & (r_state == ST_LOAD);

   assign w_acc_x_sum   = r_acc_x + {1'b0, r_org_x};
   assign w_acc_y_sum   = r_acc_y + {1'b0, r_org_y};
   assign w_cnt_x_inc   = r_cnt_x + CNT_W'(1);
   assign w_out_row_inc = r_out_row + CNT_W'(1);

   // Next-state, counters and read-issue decode.
   always_comb begin
      w_state_nx   = r_state;
      w_org_x_nx   = r_org_x;
      w_org_y_nx   = r_org_y;
      w_cnv_x_nx   = r_cnv_x;
      w_cnv_y_nx   = r_cnv_y;
      w_cnt_x_nx   = r_cnt_x;
      w_src_x_nx   = r_src_x;
      w_acc_x_nx   = r_acc_x;
      w_acc_y_nx   = r_acc_y;
      w_out_row_nx = r_out_row;
      w_in_row_nx  = r_in_row;
      w_cfg_err_nx = r_cfg_err;
      w_rd_issue   = 1'b0;
      w_rd_last    = 1'b0;

      if (DIN_FSYNC) begin
         w_org_x_nx   = ORG_X;
         w_org_y_nx   = ORG_Y;
         w_cnv_x_nx   = CNV_X;
         w_cnv_y_nx   = CNV_Y;
         w_cnt_x_nx   = '0;
         w_src_x_nx   = '0;
         w_acc_x_nx   = '0;
         w_acc_y_nx   = '0;
         w_out_row_nx = '0;
         w_in_row_nx  = '0;
         w_cfg_err_nx = w_cfg_bad;
         w_state_nx   = w_cfg_bad ? ST_DISCARD : ST_LOAD;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_xfer) begin
                  if (w_cnt_x_inc == r_org_x) begin
                     w_state_nx = ST_EMIT;
                     w_cnt_x_nx = '0;
                     w_src_x_nx = '0;
                     w_acc_x_nx = '0;
                  end else begin
                     w_cnt_x_nx = w_cnt_x_inc;
                  end
               end
            end
            ST_EMIT: begin
               w_rd_issue = 1'b1;
               w_rd_last  = (r_cnt_x == r_cnv_x - CNT_W'(1)) &&
                            (r_out_row == r_cnv_y - CNT_W'(1));
               // DDA step: src_x tracks floor(i*ORG_X/CNV_X) without a divider.
               if (w_acc_x_sum >= {1'b0, r_cnv_x}) begin
                  w_acc_x_nx = w_acc_x_sum - {1'b0, r_cnv_x};
                  w_src_x_nx = r_src_x + CNT_W'(1);
               end else begin
                  w_acc_x_nx = w_acc_x_sum;
               end
               if (w_cnt_x_inc == r_cnv_x) begin
                  w_state_nx = ST_ROWEND;
                  w_cnt_x_nx = '0;
                  w_src_x_nx = '0;
                  w_acc_x_nx = '0;
               end else begin
                  w_cnt_x_nx = w_cnt_x_inc;
               end
            end
            ST_ROWEND: begin
               w_out_row_nx = w_out_row_inc;
               if (w_out_row_inc == r_cnv_y) begin
                  w_state_nx = ST_IDLE;
               end else if (w_acc_y_sum >= {1'b0, r_cnv_y}) begin
                  w_acc_y_nx  = w_acc_y_sum - {1'b0, r_cnv_y};
                  w_in_row_nx = r_in_row + CNT_W'(1);
                  w_cnt_x_nx  = '0;
                  w_state_nx  = ST_LOAD;
               end else begin
                  w_acc_y_nx = w_acc_y_sum;
                  w_state_nx = ST_EMIT;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= ST_IDLE;
         r_org_x   <= '0;
         r_org_y   <= '0;
         r_cnv_x   <= '0;
         r_cnv_y   <= '0;
         r_cnt_x   <= '0;
         r_src_x   <= '0;
         r_acc_x   <= '0;
         r_acc_y   <= '0;
         r_out_row <= '0;
         r_in_row  <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_org_x   <= w_org_x_nx;
         r_org_y   <= w_org_y_nx;
         r_cnv_x   <= w_cnv_x_nx;
         r_cnv_y   <= w_cnv_y_nx;
         r_cnt_x   <= w_cnt_x_nx;
         r_src_x   <= w_src_x_nx;
         r_acc_x   <= w_acc_x_nx;
         r_acc_y   <= w_acc_y_nx;
         r_out_row <= w_out_row_nx;
         r_in_row  <= w_in_row_nx;
         r_cfg_err <= w_cfg_err_nx;
      end
   end

   // Line buffer: LOAD writes and EMIT reads never overlap, so no bypass is needed.
   always_ff @(posedge CLK) begin
      if (w_buf_we) begin
         r_buf[r_cnt_x[ADDR_W-1:0]] <= DIN;
      end
      r_rd_data <= r_buf[r_src_x[ADDR_W-1:0]];
   end

   // Two-stage output pipeline; a frame start drops anything still in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rd_v       <= 1'b0;
         r_rd_last    <= 1'b0;
         r_dout_oe    <= 1'b0;
         r_dout_last  <= 1'b0;
         r_dout_fsync <= 1'b0;
         r_dout       <= '0;
      end else begin
         r_dout_fsync <= DIN_FSYNC;
         if (DIN_FSYNC) begin
            r_rd_v      <= 1'b0;
            r_rd_last   <= 1'b0;
            r_dout_oe   <= 1'b0;
            r_dout_last <= 1'b0;
         end else begin
            r_rd_v      <= w_rd_issue;
            r_rd_last   <= w_rd_last;
            r_dout_oe   <= r_rd_v;
            r_dout_last <= r_rd_v & r_rd_last;
            if (r_rd_v) begin
               r_dout <= r_rd_data;
            end
         end
      end
   end

   assign DOUT_OE    = r_dout_oe;
   assign DOUT_FSYNC = r_dout_fsync;
   assign DOUT_LAST  = r_dout_last;
   assign DOUT       = r_dout;
   assign CFG_ERR    = r_cfg_err;

endmodule

// File: tb/tb_aq_expand.sv
// Bench for aq_expand: table of frame configurations plus hand-built abort and
// reset sequences; expected pixels come from a floor(i*ORG/CNV) reference model.
module tb_aq_expand;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MAX_PIX = 64;
   localparam int unsigned N_VEC   = 8;

   typedef struct {
      int org_x;
      int org_y;
      int cnv_x;
      int cnv_y;
      int we_mode;   // 0: always, 1: toggle, 2: random
      bit fsync_we;
      bit exp_err;
   } vec_t;

   typedef struct {
      logic [DATA_W-1:0] pix;
      bit                last;
      bit                first;
   } exp_t;

   logic              CLK = 1'b0;
   logic              RST_N;
   logic [15:0]       ORG_X, ORG_Y, CNV_X, CNV_Y;
   logic              DIN_FSYNC, DIN_WE;
   logic [DATA_W-1:0] DIN;
   logic              DIN_READY, DOUT_OE, DOUT_FSYNC, DOUT_LAST, CFG_ERR;
   logic [DATA_W-1:0] DOUT;

   exp_t              sb_q[$];
   vec_t              vecs [N_VEC];
   int                n_checks   = 0;
   int                n_fail     = 0;
   int                n_out      = 0;
   bit                exp_fsync  = 1'b0;
   bit                fsync_seen = 1'b0;
   bit                hold_valid = 1'b0;
   logic [DATA_W-1:0] hold_val   = '0;

   aq_expand #(.ADDR_W(11), .DATA_W(DATA_W)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .ORG_X      (ORG_X),
      .ORG_Y      (ORG_Y),
      .CNV_X      (CNV_X),
      .CNV_Y      (CNV_Y),
      .DIN_FSYNC  (DIN_FSYNC),
      .DIN_WE     (DIN_WE),
      .DIN        (DIN),
      .DIN_READY  (DIN_READY),
      .DOUT_OE    (DOUT_OE),
      .DOUT_FSYNC (DOUT_FSYNC),
      .DOUT_LAST  (DOUT_LAST),
      .DOUT       (DOUT),
      .CFG_ERR    (CFG_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Called once per cycle at the falling edge: scoreboard pop and compare.
   task automatic monitor();
      exp_t e;
      if (exp_fsync || (DOUT_FSYNC === 1'b1))
         check("dout_fsync", 32'(DOUT_FSYNC), 32'(exp_fsync));
      if (DOUT_FSYNC === 1'b1) fsync_seen = 1'b1;
      exp_fsync = 1'b0;
      if (DOUT_OE === 1'b1) begin
         n_out++;
         if (sb_q.size() == 0) begin
            check("oe_without_expected_pixel", 32'(DOUT_OE), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("dout", DOUT, e.pix);
            check("dout_last", 32'(DOUT_LAST), 32'(e.last));
            if (e.first) check("fsync_before_first_oe", 32'(fsync_seen), 32'd1);
            hold_val   = e.pix;
            hold_valid = 1'b1;
         end
      end else begin
         check("last_without_oe", 32'(DOUT_LAST), 32'd0);
         if (hold_valid) check("dout_hold", DOUT, hold_val);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      monitor();
   endtask

   task automatic run_frame(input vec_t v, input int abort_after);
      logic [DATA_W-1:0] pix [MAX_PIX];
      exp_t e;
      int   total, idx, cyc, budget, sy, sx;
      bit   we;
      total = v.org_x * v.org_y;
      for (int k = 0; k < MAX_PIX; k++) pix[k] = $urandom;
      step();
      ORG_X     = 16'(v.org_x);
      ORG_Y     = 16'(v.org_y);
      CNV_X     = 16'(v.cnv_x);
      CNV_Y     = 16'(v.cnv_y);
      DIN_FSYNC = 1'b1;
      DIN_WE    = v.fsync_we;
      DIN       = 32'hdead_beef;
      sb_q.delete();
      n_out      = 0;
      fsync_seen = 1'b0;
      exp_fsync  = 1'b1;
      if (!v.exp_err) begin
         for (int oy = 0; oy < v.cnv_y; oy++) begin
            for (int ox = 0; ox < v.cnv_x; ox++) begin
               sy      = (oy * v.org_y) / v.cnv_y;
               sx      = (ox * v.org_x) / v.cnv_x;
               e.pix   = pix[sy * v.org_x + sx];
               e.last  = (oy == v.cnv_y - 1) && (ox == v.cnv_x - 1);
               e.first = (oy == 0) && (ox == 0);
               sb_q.push_back(e);
            end
         end
      end
      #1;
      check("ready_during_fsync", 32'(DIN_READY), 32'd0);
      step();
      DIN_FSYNC = 1'b0;
      DIN_WE    = 1'b0;
      check("cfg_err", 32'(CFG_ERR), 32'(v.exp_err));
      if (v.exp_err) begin
         for (int k = 0; k < 6; k++) begin
            DIN_WE = 1'b1;
            DIN    = $urandom;
            #1;
            check("ready_in_discard", 32'(DIN_READY), 32'd1);
            step();
         end
         DIN_WE = 1'b0;
         check("cfg_err_sticky", 32'(CFG_ERR), 32'd1);
         return;
      end
      idx    = 0;
      cyc    = 0;
      budget = 4 * (v.cnv_x + v.org_x + 4) * v.cnv_y + 50;
      while ((idx < total || sb_q.size() != 0) && cyc < budget &&
             !(abort_after > 0 && n_out >= abort_after)) begin
         case (v.we_mode)
            0:       we = 1'b1;
            1:       we = (cyc % 2 == 0);
            default: we = 1'($urandom_range(0, 1));
         endcase
         DIN_WE = we;
         DIN    = (idx < total) ? pix[idx] : 32'h0bad_0bad;
         #1;
         if (idx >= total) check("ready_after_last_pixel", 32'(DIN_READY), 32'd0);
         else if (we && DIN_READY) idx++;
         step();
         cyc++;
      end
      if (abort_after > 0) begin
         check("abort_point_reached", 32'(n_out >= abort_after), 32'd1);
         return;
      end
      check("frame_drained", 32'(sb_q.size()), 32'd0);
      check("pixels_consumed", 32'(idx), 32'(total));
      DIN_WE = 1'b0;
      repeat (4) step();
      check("output_count", 32'(n_out), 32'(v.cnv_x * v.cnv_y));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vecs[0] = '{2, 2, 4, 4, 0, 1'b0, 1'b0};
      vecs[1] = '{3, 1, 5, 1, 0, 1'b0, 1'b0};
      vecs[2] = '{3, 3, 3, 3, 1, 1'b0, 1'b0};
      vecs[3] = '{5, 2, 4, 4, 0, 1'b0, 1'b1};
      vecs[4] = '{3, 2, 7, 5, 0, 1'b1, 1'b0};
      vecs[5] = '{1, 1, 1, 1, 0, 1'b0, 1'b0};
      vecs[6] = '{0, 2, 2, 2, 0, 1'b0, 1'b1};
      vecs[7] = '{4, 3, 4, 6, 2, 1'b1, 1'b0};

      RST_N     = 1'b0;
      ORG_X     = '0;
      ORG_Y     = '0;
      CNV_X     = '0;
      CNV_Y     = '0;
      DIN_FSYNC = 1'b0;
      DIN_WE    = 1'b0;
      DIN       = '0;
      repeat (3) step();
      check("rst_din_ready", 32'(DIN_READY), 32'd0);
      check("rst_dout_oe", 32'(DOUT_OE), 32'd0);
      check("rst_dout_fsync", 32'(DOUT_FSYNC), 32'd0);
      check("rst_dout_last", 32'(DOUT_LAST), 32'd0);
      check("rst_dout", DOUT, 32'd0);
      check("rst_cfg_err", 32'(CFG_ERR), 32'd0);
      hold_val   = '0;
      hold_valid = 1'b1;
      RST_N      = 1'b1;
      DIN_WE     = 1'b1;
      repeat (3) begin
         #1;
         check("idle_not_ready", 32'(DIN_READY), 32'd0);
         step();
      end
      DIN_WE = 1'b0;

      for (int i = 0; i < N_VEC; i++) run_frame(vecs[i], 0);

      // Frame aborted mid-stream by a new frame start.
      run_frame('{4, 4, 8, 8, 0, 1'b0, 1'b0}, 20);
      run_frame('{2, 2, 2, 2, 0, 1'b0, 1'b0}, 0);

      // Asynchronous reset in the middle of row replay.
      run_frame('{4, 4, 8, 8, 0, 1'b0, 1'b0}, 10);
      RST_N = 1'b0;
      #1;
      check("midrst_dout_oe", 32'(DOUT_OE), 32'd0);
      check("midrst_dout", DOUT, 32'd0);
      check("midrst_dout_last", 32'(DOUT_LAST), 32'd0);
      check("midrst_dout_fsync", 32'(DOUT_FSYNC), 32'd0);
      check("midrst_din_ready", 32'(DIN_READY), 32'd0);
      check("midrst_cfg_err", 32'(CFG_ERR), 32'd0);
      sb_q.delete();
      hold_val = '0;
      DIN_WE   = 1'b1;
      repeat (2) step();
      RST_N = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("ready_after_reset", 32'(DIN_READY), 32'd0);
         step();
      end
      DIN_WE = 1'b0;
      run_frame('{2, 2, 3, 3, 2, 1'b0, 1'b0}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
